step_ramp_generator: RTL

- Upstream neighbour of the step generator. Drives its signed pulse-period input (sign = direction, magnitude = clk cycles per step, 0 = stop) so that period changes ramp instead of jumping.
- Walks the current period towards a requested period at a programmable rate.
- A direction reversal always decelerates to stop before restarting in the new direction.
- Owns no step/dir pins; its output connects directly to the step generator's pulsewidth control.

---
 rtl/step_ramp_pkg.sv | 33 +++
 rtl/ramp_prescaler.sv | 30 +++
 rtl/step_ramp_generator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/step_ramp_pkg.sv
// Shared types, limits and saturating helpers for the step ramp generator.
// Magnitudes are unsigned PW_W-1 bit values; the sign lives in a separate dir bit.
package step_ramp_pkg;

   typedef enum logic [1:0] {
      STOPPED,
      RUN,
      DECEL
   } ramp_state_t;

   localparam int PW_W  = 17;
   localparam int DIV_W = 16;
   localparam int MAG_W = PW_W - 1;

   localparam logic [MAG_W-1:0] MAG_MAX = '1;

   function automatic logic [MAG_W-1:0] sat_add(
      input logic [MAG_W-1:0] a,
      input logic [MAG_W-1:0] b
   );
      logic [MAG_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[MAG_W] ? MAG_MAX : s[MAG_W-1:0];
   endfunction

   function automatic logic [MAG_W-1:0] sat_sub(
      input logic [MAG_W-1:0] a,
      input logic [MAG_W-1:0] b
   );
      return (b > a) ? '0 : (a - b);
   endfunction

endpackage

// File: rtl/ramp_prescaler.sv
// Update-tick prescaler: counts 0..update_div, tick on the compare cycle.
// Ports: clk, resetn, clr (sync clear, suppresses tick), update_div, tick.
module ramp_prescaler
   import step_ramp_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_W
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 clr,
   input  logic [DIV_WIDTH-1:0] update_div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt_q;

   // >= so a divider lowered below the count wraps on the next compare
   assign tick = ~clr & (cnt_q >= update_div);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/step_ramp_generator.sv
// Ramps a signed step period towards target_pw, decelerating to stop on reversal.
// Ports: clk, resetn, enable, estop, target_pw, start_pw, accel_step, update_div -> pulsewidth, moving, at_target, reversing.
module step_ramp_generator
   import step_ramp_pkg::*;
#(
   parameter int PW_WIDTH  = PW_W,
   parameter int DIV_WIDTH = DIV_W
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       enable,
   input  logic                       estop,
   input  logic signed [PW_WIDTH-1:0] target_pw,
   input  logic [PW_WIDTH-2:0]        start_pw,
   input  logic [PW_WIDTH-2:0]        accel_step,
   input  logic [DIV_WIDTH-1:0]       update_div,
   output logic signed [PW_WIDTH-1:0] pulsewidth,
   output logic                       moving,
   output logic                       at_target,
   output logic                       reversing
);

   localparam int MW = PW_WIDTH - 1;

   logic                clr;
   logic                tick;
   ramp_state_t         state_q;
   ramp_state_t         state_d;
   logic [MW-1:0]       mag_q;
   logic [MW-1:0]       mag_d;
   logic                dir_q;
   logic                dir_d;
   logic [PW_WIDTH-1:0] neg_t;
   logic [MW-1:0]       tm;
   logic                td;
   logic                keep_dir;
   logic [MW-1:0]       dn;
   logic [MW-1:0]       up;
   logic [MW-1:0]       run_mag;
   logic [MW:0]         nxt;
   logic                stop_now;
   logic signed [PW_WIDTH-1:0] pw_d;

   assign clr = ~enable | estop;

   ramp_prescaler #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_pre (
      .clk        (clk),
      .resetn     (resetn),
      .clr        (clr),
      .update_div (update_div),
      .tick       (tick)
   );

   // |target|; the most negative target negates to itself and saturates
   assign td    = target_pw[PW_WIDTH-1];
   assign neg_t = -target_pw;
   assign tm    = !td ? target_pw[MW-1:0]
                : neg_t[MW] ? '1 : neg_t[MW-1:0];

   assign keep_dir = (tm != '0) && (td == dir_q);

   assign dn = sat_sub(mag_q, accel_step);
   assign up = sat_add(mag_q, accel_step);

   // one bit wider so an overflow past the range forces the stop
   assign nxt      = {1'b0, mag_q} + {1'b0, accel_step};
   assign stop_now = (accel_step == '0) || nxt[MW]
                   || (nxt >= {1'b0, start_pw});

   always_comb begin
      run_mag = mag_q;
      if (accel_step == '0) begin
         run_mag = tm;
      end else if (mag_q > tm) begin
         run_mag = (dn < tm) ? tm : dn;
      end else if (mag_q < tm) begin
         run_mag = (up > tm) ? tm : up;
      end
   end

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      dir_d   = dir_q;
      unique case (state_q)
         STOPPED: begin
            if (tm != '0) begin
               dir_d   = td;
               mag_d   = (accel_step == '0 || tm > start_pw)
                       ? tm : start_pw;
               state_d = RUN;
            end
         end
         RUN, DECEL: begin
            if (keep_dir) begin
               mag_d   = run_mag;
               state_d = RUN;
            end else if (stop_now) begin
               mag_d   = '0;
               state_d = STOPPED;
            end else begin
               mag_d   = nxt[MW-1:0];
               state_d = DECEL;
            end
         end
         default: begin
            mag_d   = '0;
            state_d = STOPPED;
         end
      endcase
   end

   assign pw_d = dir_d ? -{1'b0, mag_d} : {1'b0, mag_d};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= STOPPED;
         mag_q      <= '0;
         dir_q      <= 1'b0;
         pulsewidth <= '0;
         moving     <= 1'b0;
         at_target  <= 1'b1;
         reversing  <= 1'b0;
      end else if (clr) begin
         state_q    <= STOPPED;
         mag_q      <= '0;
         dir_q      <= 1'b0;
         pulsewidth <= '0;
         moving     <= 1'b0;
         at_target  <= 1'b1;
         reversing  <= 1'b0;
      end else if (tick) begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         dir_q      <= dir_d;
         pulsewidth <= pw_d;
         moving     <= (mag_d != '0);
         at_target  <= (pw_d == target_pw);
         reversing  <= (state_d == DECEL) && (tm != '0);
      end
   end

endmodule
